fifo_paced_reader: RTL and testbench
====================================

Name: fifo_paced_reader

Overview:
- Read-side consumer for the dual-clock FIFO; a parametrised successor to the fixed 16-bit reader/hex-display path.
- Pops words at a programmable pace (continuous mode) or one per step request (step mode), holds the word, and drives one 7-segment digit per nibble.
- Keeps a popped-word count and reports starvation.
- Sits entirely in the FIFO read clock domain.

Parameters:
DATA_W, 16, FIFO word width; must be a multiple of 4; NDIG = DATA_W/4.
PERIOD, 10000000, minimum cycles between consecutive pops in continuous mode; must be >= 2.
CNT_W, 16, width of the popped-word counter.

Ports:
Clk  in  1  read-domain clock
Rst_n  in  1  synchronous active-low reset
rdata  in  DATA_W  FIFO head word; valid whenever rempty=0 (show-ahead)
rempty  in  1  FIFO empty flag
rinc  out  1  FIFO pop strobe
mode_i  in  1  0 = continuous, 1 = step
step_i  in  1  step request (single-cycle pulse, synchronous)
data_o  out  DATA_W  last popped word
valid_o  out  1  one-cycle pulse when data_o updates
seg_o  out  8*NDIG  digit k in bits [8k+7:8k], showing nibble k
word_cnt_o  out  CNT_W  number of words popped, wrapping
starve_o  out  1  level: pace/step wanted a word but FIFO empty

Behaviour:
- Reset, synchronous on Rst_n=0 at a Clk edge, overrides everything including a pop in progress:
  - Outputs: rinc=0, data_o=0, valid_o=0, word_cnt_o=0, starve_o=0.
  - Internal: state=WAIT, hold counter=0, step_pending=0, seen_data=0.
  - seg_o shows a dash on every digit (8'hBF).
- step_pending:
  - Set on any cycle with step_i=1. Cleared on entry to POP.
  - Multiple steps while pending collapse into one.
  - step_i is ignored in continuous mode, but it still sets pending.
- Pop is eligible when (mode_i=0) or (mode_i=1 and step_pending=1).
- State WAIT:
  - Eligible and rempty=0 -> POP.
  - Eligible and rempty=1 -> starve_o=1, stay in WAIT.
  - Not eligible -> starve_o=0.
- State POP (exactly 1 cycle):
  - rinc=1.
  - data_o<=rdata on this edge; valid_o=1 in the following cycle.
  - word_cnt_o increments, wrapping at 2^CNT_W.
  - seen_data<=1. Hold counter loads PERIOD-2. Next state is HOLD.
  - rinc is a registered state decode. Only this block pops, so rempty cannot rise before the pop.
- State HOLD:
  - Counter decrements each cycle; at 0 -> WAIT.
  - In continuous mode with a non-empty FIFO, rinc pulses are exactly PERIOD cycles apart.
  - In step mode HOLD still applies, giving a minimum spacing of PERIOD cycles.
  - mode_i changes take effect only at the next WAIT evaluation.
  - starve_o=0 in POP and HOLD.
- Segment encoding:
  - Registered from data_o, so seg_o lags data_o by 1 cycle.
  - Active-low, bit7 = DP (always 1), bits 6..0 = g..a.
  - Codes 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
  - Dash (BF) on all digits until seen_data=1.
- Arithmetic: all counters unsigned; hold counter width is clog2(PERIOD).
- Simultaneous events:
  - step_i during POP sets pending for the next pop.
  - step_i in the same cycle as the WAIT->POP decision is consumed by that pop.

Test Plan:
- Reset value: PERIOD=4, DATA_W=16, hold Rst_n=0 for 3 cycles with FIFO non-empty -> rinc=0, data_o=0, word_cnt_o=0, seg_o=BFBFBFBF throughout.
- Continuous pacing: FIFO preloaded with 1234, ABCD, 0F0F; release reset, mode_i=0.
  - 3 rinc pulses exactly 4 cycles apart; data_o sequence 1234, ABCD, 0F0F; valid_o pulses 1 cycle after each rinc.
  - word_cnt_o=3; seg_o after the second word = 88,83,C6,A1 (digit3..0).
  - starve_o=1 from the first WAIT after the third HOLD.
- Step mode: mode_i=1, FIFO holds 5 words; 2 step_i pulses 1 cycle apart, then wait 20 cycles -> exactly 1 pop; a third step 10 cycles later -> second pop, word_cnt_o=2.
- Starvation recovery: continuous mode, empty FIFO, starve_o=1; push 00FF -> rinc within 1 cycle of rempty falling; starve_o=0; data_o=00FF; seg_o digits C0,C0,8E,8E.
- Reset mid-operation: assert Rst_n=0 in the POP cycle -> data_o stays 0, word_cnt_o=0, seg_o dashes; the FIFO pop of that cycle is the FIFO's responsibility.
- Counter wrap: CNT_W=2, 5 pops -> word_cnt_o sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fifo_paced_reader.sv
// Read-side consumer for the dual-clock FIFO: pops words at a programmed pace or on
// step requests, holds the last word and drives one active-low 7-segment digit per nibble.
module fifo_paced_reader #(
   parameter int DATA_W = 16,
   parameter int PERIOD = 10000000,
   parameter int CNT_W  = 16
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic [DATA_W-1:0]   rdata,
   input  logic                rempty,
   output logic                rinc,
   input  logic                mode_i,
   input  logic                step_i,
   output logic [DATA_W-1:0]   data_o,
   output logic                valid_o,
   output logic [2*DATA_W-1:0] seg_o,
   output logic [CNT_W-1:0]    word_cnt_o,
   output logic                starve_o
);

   localparam int NDIG = DATA_W / 4;
   localparam int HC_W = $clog2(PERIOD);
   localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(PERIOD - 2);

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_POP  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [HC_W-1:0]       hold_q, hold_d;
   logic                  pend_q, pend_d;
   logic                  rinc_q;
   logic                  eligible;
   logic [DATA_W-1:0]     data_q;
   logic                  valid_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  seen_q;
   logic [2*DATA_W-1:0]   seg_q, seg_d;

   function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
      logic [7:0] s;
      case (nib)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   assign eligible = ~mode_i | pend_q;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= S_WAIT;
         hold_q  <= '0;
         pend_q  <= 1'b0;
         rinc_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         pend_q  <= pend_d;
         rinc_q  <= (state_d == S_POP);
      end
   end

   // HOLD leaves on the cycle it would reach 0, so WAIT decides PERIOD-1 cycles after POP
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      pend_d  = pend_q | step_i;
      case (state_q)
         S_WAIT: begin
            if (eligible && !rempty) begin
               state_d = S_POP;
               pend_d  = 1'b0;
            end
         end
         S_POP: begin
            state_d = S_HOLD;
            hold_d  = HOLD_LOAD;
         end
         S_HOLD: begin
            if (hold_q <= HC_W'(1)) state_d = S_WAIT;
            else                    hold_d  = hold_q - HC_W'(1);
         end
         default: state_d = S_WAIT;
      endcase
   end

   always_comb begin
      rinc     = rinc_q;
      starve_o = Rst_n & (state_q == S_WAIT) & eligible & rempty;
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         seen_q  <= 1'b0;
         seg_q   <= {NDIG{8'hBF}};
      end else begin
         valid_q <= (state_q == S_POP);
         if (state_q == S_POP) begin
            data_q <= rdata;
            cnt_q  <= cnt_q + CNT_W'(1);
            seen_q <= 1'b1;
         end
         seg_q <= seg_d;
      end
   end

   // Dashes until the first word has been captured
   always_comb begin
      seg_d = '1;
      for (int k = 0; k < NDIG; k++) begin
         seg_d[8*k +: 8] = seen_q ? hex_to_seg(data_q[4*k +: 4]) : 8'hBF;
      end
   end

   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign word_cnt_o = cnt_q;
   assign seg_o      = seg_q;

endmodule

// File: tb/tb_fifo_paced_reader.sv
// Bench for fifo_paced_reader: show-ahead FIFO model, pacing/step reference model
// compared every cycle, plus directed literal expectations per scenario.
module tb_fifo_paced_reader;

   localparam int DATA_W = 16;
   localparam int PERIOD = 4;
   localparam int CNT_W  = 2;

   logic        clk = 1'b0;
   logic        rst_n, mode, step;
   logic [15:0] rdata;
   logic        rempty, rinc;
   logic [15:0] data_o;
   logic        valid_o;
   logic [31:0] seg_o;
   logic [1:0]  cnt_o;
   logic        starve;

   always #5 clk = ~clk;

   logic [15:0] mem [0:255];
   int n_push = 0;
   int n_pop  = 0;

   assign rempty = (n_push == n_pop);
   assign rdata  = mem[n_pop % 256];

   always @(posedge clk) begin
      if (rinc && (n_pop != n_push)) n_pop <= n_pop + 1;
   end

   fifo_paced_reader #(.DATA_W(DATA_W), .PERIOD(PERIOD), .CNT_W(CNT_W)) dut (
      .Clk(clk), .Rst_n(rst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
      .mode_i(mode), .step_i(step), .data_o(data_o), .valid_o(valid_o),
      .seg_o(seg_o), .word_cnt_o(cnt_o), .starve_o(starve)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // reference state: spacing measured in cycles since the last pop
   bit          m_on = 1'b0;
   logic        m_rinc = 1'b0, m_valid = 1'b0, m_seen = 1'b0, m_pend = 1'b0;
   logic [15:0] m_data = '0;
   logic [31:0] m_seg = 32'hBFBFBFBF;
   int          m_cnt = 0, m_since = 1000, cyc_n = 0;
   logic        prev_valid = 1'b0;

   int          pop_cyc[$];
   logic [15:0] vdata[$];
   int          vcnt[$];
   logic [31:0] seg_after[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
      end
   endtask

   function automatic logic [31:0] enc(input logic [15:0] d);
      logic [31:0] s;
      for (int k = 0; k < 4; k++) s[8*k +: 8] = seg_tab[d[4*k +: 4]];
      return s;
   endfunction

   task automatic model_step();
      logic in_wait, elig, exp_starve, pop_n;
      logic [31:0] seg_n;
      in_wait    = !m_rinc && (m_since >= PERIOD - 1);
      elig       = !mode || m_pend;
      exp_starve = rst_n && in_wait && elig && rempty;
      if (m_on) begin
         chk("rinc", 32'(rinc), 32'(m_rinc));
         chk("data_o", 32'(data_o), 32'(m_data));
         chk("valid_o", 32'(valid_o), 32'(m_valid));
         chk("word_cnt_o", 32'(cnt_o), 32'(m_cnt));
         chk("seg_o", seg_o, m_seg);
         chk("starve_o", 32'(starve), 32'(exp_starve));
         if (rinc === 1'b1) pop_cyc.push_back(cyc_n);
         if (valid_o === 1'b1) begin
            vdata.push_back(data_o);
            vcnt.push_back(int'(cnt_o));
         end
         if (prev_valid) seg_after.push_back(seg_o);
         prev_valid = (valid_o === 1'b1);
      end
      if (!rst_n) begin
         m_on = 1'b1; m_rinc = 1'b0; m_valid = 1'b0; m_seen = 1'b0; m_pend = 1'b0;
         m_data = '0; m_seg = 32'hBFBFBFBF; m_cnt = 0; m_since = 1000; prev_valid = 1'b0;
      end else if (m_on) begin
         seg_n   = m_seen ? enc(m_data) : 32'hBFBFBFBF;
         pop_n   = in_wait && elig && !rempty;
         m_valid = m_rinc;
         if (m_rinc) begin
            m_data = rdata;
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            m_seen = 1'b1;
         end
         m_seg   = seg_n;
         m_pend  = pop_n ? 1'b0 : (m_pend | step);
         m_since = pop_n ? 0 : ((m_since < 1000) ? m_since + 1 : 1000);
         m_rinc  = pop_n;
      end
      cyc_n++;
   endtask

   task automatic cyc();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic push(input logic [15:0] v);
      mem[n_push % 256] = v;
      n_push++;
   endtask

   task automatic clear_logs();
      pop_cyc.delete();
      vdata.delete();
      vcnt.delete();
      seg_after.delete();
   endtask

   int fall;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      rst_n = 1'b0;
      mode  = 1'b0;
      step  = 1'b0;
      push(16'h1234); push(16'hABCD); push(16'h0F0F);
      @(posedge clk); #2;

      // reset held with a non-empty FIFO
      repeat (3) begin
         cyc();
         chk("rst rinc", 32'(rinc), 32'd0);
         chk("rst data_o", 32'(data_o), 32'd0);
         chk("rst word_cnt_o", 32'(cnt_o), 32'd0);
         chk("rst seg_o", seg_o, 32'hBFBFBFBF);
      end

      // continuous pacing
      clear_logs();
      rst_n = 1'b1;
      run(16);
      chk("cont pop count", pop_cyc.size(), 32'd3);
      if (pop_cyc.size() == 3) begin
         chk("cont gap1", pop_cyc[1] - pop_cyc[0], 32'd4);
         chk("cont gap2", pop_cyc[2] - pop_cyc[1], 32'd4);
      end
      chk("cont valid count", vdata.size(), 32'd3);
      if (vdata.size() == 3) begin
         chk("cont word0", 32'(vdata[0]), 32'h1234);
         chk("cont word1", 32'(vdata[1]), 32'hABCD);
         chk("cont word2", 32'(vdata[2]), 32'h0F0F);
      end
      if (seg_after.size() >= 2) chk("cont seg word1", seg_after[1], 32'h8883C6A1);
      else chk("cont seg log size", seg_after.size(), 32'd2);
      chk("cont word_cnt_o", 32'(cnt_o), 32'd3);
      chk("cont starve", 32'(starve), 32'd1);

      // step mode
      rst_n = 1'b0;
      mode  = 1'b1;
      run(2);
      n_push = n_pop;
      push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444); push(16'h5555);
      clear_logs();
      rst_n = 1'b1;
      run(2);
      step = 1'b1; cyc();
      step = 1'b1; cyc();
      step = 1'b0;
      run(20);
      chk("step pops after two steps", pop_cyc.size(), 32'd1);
      chk("step word_cnt_o 1", 32'(cnt_o), 32'd1);
      if (vdata.size() >= 1) chk("step word0", 32'(vdata[0]), 32'h1111);
      step = 1'b1; cyc();
      step = 1'b0;
      run(10);
      chk("step pops after third step", pop_cyc.size(), 32'd2);
      chk("step word_cnt_o 2", 32'(cnt_o), 32'd2);
      chk("step data_o", 32'(data_o), 32'h2222);

      // starvation and recovery
      rst_n = 1'b0;
      mode  = 1'b0;
      run(2);
      n_push = n_pop;
      clear_logs();
      rst_n = 1'b1;
      run(4);
      chk("starve level", 32'(starve), 32'd1);
      chk("starve no pop", pop_cyc.size(), 32'd0);
      fall = cyc_n;
      push(16'h00FF);
      cyc();
      cyc();
      if (pop_cyc.size() >= 1) chk("recover pop latency", pop_cyc[0] - fall, 32'd1);
      else chk("recover pop count", pop_cyc.size(), 32'd1);
      chk("recover data_o", 32'(data_o), 32'h00FF);
      chk("recover starve", 32'(starve), 32'd0);
      cyc();
      chk("recover seg_o", seg_o, 32'hC0C08E8E);

      // reset landing on the POP cycle
      rst_n = 1'b0;
      run(2);
      n_push = n_pop;
      push(16'hAAAA); push(16'hBBBB);
      rst_n = 1'b1;
      cyc();
      chk("midrst rinc in pop", 32'(rinc), 32'd1);
      rst_n = 1'b0;
      cyc();
      chk("midrst data_o", 32'(data_o), 32'd0);
      chk("midrst word_cnt_o", 32'(cnt_o), 32'd0);
      chk("midrst valid_o", 32'(valid_o), 32'd0);
      chk("midrst seg_o", seg_o, 32'hBFBFBFBF);
      run(1);

      // word counter wrap with a 2-bit counter
      n_push = n_pop;
      push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0004); push(16'h0005);
      clear_logs();
      rst_n = 1'b1;
      run(22);
      chk("wrap valid count", vcnt.size(), 32'd5);
      if (vcnt.size() == 5) begin
         chk("wrap cnt0", vcnt[0], 32'd1);
         chk("wrap cnt1", vcnt[1], 32'd2);
         chk("wrap cnt2", vcnt[2], 32'd3);
         chk("wrap cnt3", vcnt[3], 32'd0);
         chk("wrap cnt4", vcnt[4], 32'd1);
      end
      chk("wrap final cnt", 32'(cnt_o), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
